// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core: control bundle layout,
// EXE_CMD encodings and the pipeline-register action type.
package core_pkg;

  localparam int CTRL_W = 9;

  // Bit positions inside the decoder control bundle.
  localparam int CTRL_WB     = 8;
  localparam int CTRL_MR     = 7;
  localparam int CTRL_MW     = 6;
  localparam int CTRL_CMD_HI = 5;
  localparam int CTRL_CMD_LO = 2;
  localparam int CTRL_B      = 1;
  localparam int CTRL_S      = 0;

  // ALU command encodings carried in EXE_CMD.
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  // The single action a pipeline register performs on a clock edge
  // (reset is handled separately inside the flops).
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_e;

  // Extract the ALU command field from a control bundle.
  function automatic logic [3:0] ctrl_exe_cmd(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_CMD_HI:CTRL_CMD_LO];
  endfunction

endpackage

// File: rtl/id_exe_reg_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: increment only while below the all-ones ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_exe_reg.sv
// Decode-to-execute pipeline register with flush, freeze and hazard-bubble
// handling, plus saturating bubble/flush counters for performance debug.
module id_exe_reg
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              hazard,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic              carry_in,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [3:0]        exe_cmd,
  output logic              b,
  output logic              s,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic              carry,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm24,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_act_e act;

  logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] pc_q,     pc_d;
  logic [DATA_W-1:0] rn_q,     rn_d;
  logic [DATA_W-1:0] rm_q,     rm_d;
  logic              imm_q,    imm_d;
  logic              carry_q,  carry_d;
  logic [11:0]       shop_q,   shop_d;
  logic [23:0]       simm_q,   simm_d;
  logic [3:0]        dest_q,   dest_d;
  logic [3:0]        src1_q,   src1_d;
  logic [3:0]        src2_q,   src2_d;

  // Pick the one action for this edge: flush beats freeze beats hazard.
  always_comb begin
    act = ACT_LOAD;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (freeze) begin
      act = ACT_HOLD;
    end else if (hazard) begin
      act = ACT_BUBBLE;
    end
  end

  // Next-state for every field according to the selected action.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    imm_d   = imm_q;
    carry_d = carry_q;
    shop_d  = shop_q;
    simm_d  = simm_q;
    dest_d  = dest_q;
    src1_d  = src1_q;
    src2_d  = src2_q;

    // Bubbles and loads both capture the data fields; they differ only in
    // whether the control bundle is kept or zeroed.
    if ((act == ACT_LOAD) || (act == ACT_BUBBLE)) begin
      pc_d    = pc_in;
      rn_d    = val_rn_in;
      rm_d    = val_rm_in;
      imm_d   = imm_in;
      carry_d = carry_in;
      shop_d  = shift_operand_in;
      simm_d  = signed_imm24_in;
      dest_d  = dest_in;
      src1_d  = src1_in;
      src2_d  = src2_in;
    end

    case (act)
      ACT_LOAD: begin
        ctrl_d  = ctrl_in;
        valid_d = 1'b1;
      end
      ACT_BUBBLE: begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end
      ACT_FLUSH: begin
        ctrl_d  = '0;
        valid_d = 1'b0;
        pc_d    = '0;
        rn_d    = '0;
        rm_d    = '0;
        imm_d   = 1'b0;
        carry_d = 1'b0;
        shop_d  = '0;
        simm_d  = '0;
        dest_d  = '0;
        src1_d  = '0;
        src2_d  = '0;
      end
      default: ; // ACT_HOLD keeps the defaults
    endcase
  end

  // Stage registers; reset wins even while frozen.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= 1'b0;
      carry_q <= 1'b0;
      shop_q  <= '0;
      simm_q  <= '0;
      dest_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      imm_q   <= imm_d;
      carry_q <= carry_d;
      shop_q  <= shop_d;
      simm_q  <= simm_d;
      dest_q  <= dest_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ACT_BUBBLE),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ACT_FLUSH),
    .count (flush_cnt)
  );

  assign wb_en         = ctrl_q[CTRL_WB];
  assign mem_r_en      = ctrl_q[CTRL_MR];
  assign mem_w_en      = ctrl_q[CTRL_MW];
  assign exe_cmd       = ctrl_exe_cmd(ctrl_q);
  assign b             = ctrl_q[CTRL_B];
  assign s             = ctrl_q[CTRL_S];
  assign valid_out     = valid_q;
  assign pc            = pc_q;
  assign val_rn        = rn_q;
  assign val_rm        = rm_q;
  assign imm           = imm_q;
  assign carry         = carry_q;
  assign shift_operand = shop_q;
  assign signed_imm24  = simm_q;
  assign dest          = dest_q;
  assign src1          = src1_q;
  assign src2          = src2_q;

endmodule
